// File: rtl/timepulse_sequencer_pkg.sv
// timepulse_sequencer_pkg: shared FSM encodings, counter width and index-width helper.
package timepulse_sequencer_pkg;
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;
  localparam int MCT_CNT_W = 16;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/timepulse_sequencer_onehot_ring.sv
// onehot_ring: one-hot register with rotate-advance, load-by-index and clear; resets to bit 0.
module onehot_ring
  import timepulse_sequencer_pkg::*;
#(
  parameter int N = 4,
  parameter int W = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv_i,
  input  logic         ld_i,
  input  logic         clr_i,
  input  logic [W-1:0] idx_i,
  output logic [N-1:0] q_o
);
  logic [N-1:0] q_q, q_d;
  always_comb q_d = clr_i ? '0 : ld_i ? (N'(1) << idx_i) : adv_i ? {q_q[N-2:0], q_q[N-1]} : q_q;
  always_ff @(posedge clk) q_q <= rst ? N'(1) : q_d;
  assign q_o = q_q;
endmodule

// File: rtl/timepulse_sequencer.sv
// timepulse_sequencer: T/PHS one-hot rings with RT/WT/CT strobes, stop/step hold and GOJAM restart.
module timepulse_sequencer
  import timepulse_sequencer_pkg::*;
#(
  parameter int NTP   = 12,
  parameter int NPH   = 4,
  parameter int RT_PH = 1,
  parameter int WT_PH = 2,
  parameter int CT_PH = 3,
  parameter int TPW   = $clog2(NTP)
) (
  input  logic                 CLOCK,
  input  logic                 SIM_RST,
  input  logic                 EN,
  input  logic                 GOJAM,
  input  logic                 STOP_REQ,
  input  logic                 MSTP,
  input  logic                 MSTRTP,
  output logic [NTP-1:0]       T,
  output logic [NTP-1:0]       T_n,
  output logic [NPH-1:0]       PHS,
  output logic                 RT,
  output logic                 WT,
  output logic                 CT,
  output logic [TPW-1:0]       TP_IDX,
  output logic                 MCT_END,
  output logic                 STOPPED,
  output logic [MCT_CNT_W-1:0] MCT_CNT
);
  localparam int PHW = idx_w(NPH);
  localparam logic [TPW-1:0] TP_LAST = TPW'(NTP - 1);
  localparam logic [PHW-1:0] PH_LAST = PHW'(NPH - 1);
  logic [0:0] state_q, state_d;
  logic [TPW-1:0] tp_q, tp_d, t_idx;
  logic [PHW-1:0] ph_q, ph_d;
  logic [MCT_CNT_W-1:0] cnt_q, cnt_d;
  logic step_q, step_d, rt_q, wt_q, ct_q, me_q, me_d, stb;
  logic t_adv, t_ld, t_clr, p_adv, p_ld, p_clr;
  logic ph_wrap, boundary, hold_exit;
  assign ph_wrap   = ph_q == PH_LAST;
  assign boundary  = ph_wrap && tp_q == TP_LAST;
  assign hold_exit = EN && !STOP_REQ && (!MSTP || step_q || MSTRTP);
  // Strobes fire only on an EN-driven entry into a phase, never on GOJAM/reset loads.
  always_comb begin
    state_d = state_q;
    tp_d    = tp_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    me_d    = 1'b0;
    stb     = 1'b0;
    t_idx   = '0;
    t_adv   = 1'b0;
    t_ld    = 1'b0;
    t_clr   = 1'b0;
    p_adv   = 1'b0;
    p_ld    = 1'b0;
    p_clr   = 1'b0;
    if (GOJAM) begin
      state_d = ST_RUN;
      tp_d    = TP_LAST;
      ph_d    = '0;
      step_d  = 1'b0;
      t_idx   = TP_LAST;
      t_ld    = 1'b1;
      p_ld    = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (EN) begin
        ph_d = ph_wrap ? '0 : ph_q + PHW'(1);
        tp_d = boundary ? '0 : ph_wrap ? tp_q + TPW'(1) : tp_q;
        if (boundary) begin
          me_d  = 1'b1;
          cnt_d = cnt_q + MCT_CNT_W'(1);
        end
        if (boundary && (STOP_REQ || MSTP)) begin
          state_d = ST_HOLD;
          t_clr   = 1'b1;
          p_clr   = 1'b1;
        end else begin
          stb   = 1'b1;
          t_adv = ph_wrap;
          p_adv = 1'b1;
        end
      end
    end else begin
      step_d = step_q | MSTRTP;
      if (hold_exit) begin
        state_d = ST_RUN;
        step_d  = 1'b0;
        tp_d    = '0;
        ph_d    = '0;
        stb     = 1'b1;
        t_ld    = 1'b1;
        p_ld    = 1'b1;
      end
    end
  end
  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      state_q <= ST_RUN;
      tp_q    <= '0;
      ph_q    <= '0;
      cnt_q   <= '0;
      step_q  <= 1'b0;
      me_q    <= 1'b0;
      rt_q    <= 1'b0;
      wt_q    <= 1'b0;
      ct_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tp_q    <= tp_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      me_q    <= me_d;
      rt_q    <= stb && ph_d == PHW'(RT_PH);
      wt_q    <= stb && ph_d == PHW'(WT_PH);
      ct_q    <= stb && ph_d == PHW'(CT_PH);
    end
  end
  onehot_ring #(.N(NTP), .W(TPW)) u_t_ring (
    .clk(CLOCK), .rst(SIM_RST), .adv_i(t_adv), .ld_i(t_ld), .clr_i(t_clr), .idx_i(t_idx), .q_o(T)
  );
  onehot_ring #(.N(NPH), .W(PHW)) u_p_ring (
    .clk(CLOCK), .rst(SIM_RST), .adv_i(p_adv), .ld_i(p_ld), .clr_i(p_clr), .idx_i('0), .q_o(PHS)
  );
  assign T_n     = ~T;
  assign RT      = rt_q;
  assign WT      = wt_q;
  assign CT      = ct_q;
  assign TP_IDX  = tp_q;
  assign MCT_END = me_q;
  assign STOPPED = state_q == ST_HOLD;
  assign MCT_CNT = cnt_q;
endmodule

// File: tb/tb_timepulse_sequencer.sv
// tb_timepulse_sequencer: directed vector table plus hand-written step/GOJAM/reset sequences.
module tb_timepulse_sequencer;
  logic CLOCK = 1'b0;
  logic SIM_RST, EN, GOJAM, STOP_REQ, MSTP, MSTRTP;
  logic [11:0] T, T_n;
  logic [3:0] PHS, TP_IDX;
  logic RT, WT, CT, MCT_END, STOPPED;
  logic [15:0] MCT_CNT;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic rst, en, go, stp, mstp, mstrtp;
    logic [11:0] t;
    logic [3:0] phs;
    logic rt, wt, ct, me, st;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[15];

  timepulse_sequencer dut (
    .CLOCK(CLOCK), .SIM_RST(SIM_RST), .EN(EN), .GOJAM(GOJAM), .STOP_REQ(STOP_REQ),
    .MSTP(MSTP), .MSTRTP(MSTRTP), .T(T), .T_n(T_n), .PHS(PHS), .RT(RT), .WT(WT), .CT(CT),
    .TP_IDX(TP_IDX), .MCT_END(MCT_END), .STOPPED(STOPPED), .MCT_CNT(MCT_CNT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive(input logic rst, en, go, stp, mstp, mstrtp);
    SIM_RST = rst; EN = en; GOJAM = go; STOP_REQ = stp; MSTP = mstp; MSTRTP = mstrtp;
  endtask

  function automatic logic [3:0] idx_of(input logic [11:0] t);
    logic [3:0] r = '0;
    for (int i = 0; i < 12; i++) if (t[i]) r = 4'(i);
    return r;
  endfunction

  function automatic logic [40:0] obs();
    return {T, PHS, RT, WT, CT, MCT_END, STOPPED, MCT_CNT, TP_IDX};
  endfunction

  localparam logic [40:0] RESET_OBS = {12'h001, 4'h1, 5'b00000, 16'h0000, 4'h0};

  initial begin
    vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h001,4'h2, 1'b1,1'b0,1'b0,1'b0,1'b0, 16'd0};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 12'h001,4'h2, 1'b0,1'b0,1'b0,1'b0,1'b0, 16'd0};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h001,4'h4, 1'b0,1'b1,1'b0,1'b0,1'b0, 16'd0};
    vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h001,4'h8, 1'b0,1'b0,1'b1,1'b0,1'b0, 16'd0};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h002,4'h1, 1'b0,1'b0,1'b0,1'b0,1'b0, 16'd0};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h002,4'h2, 1'b1,1'b0,1'b0,1'b0,1'b0, 16'd0};
    vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 12'h800,4'h1, 1'b0,1'b0,1'b0,1'b0,1'b0, 16'd0};
    vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h800,4'h2, 1'b1,1'b0,1'b0,1'b0,1'b0, 16'd0};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h800,4'h4, 1'b0,1'b1,1'b0,1'b0,1'b0, 16'd0};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h800,4'h8, 1'b0,1'b0,1'b1,1'b0,1'b0, 16'd0};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 12'h000,4'h0, 1'b0,1'b0,1'b0,1'b1,1'b1, 16'd1};
    vecs[11] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 12'h000,4'h0, 1'b0,1'b0,1'b0,1'b0,1'b1, 16'd1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 12'h000,4'h0, 1'b0,1'b0,1'b0,1'b0,1'b1, 16'd1};
    vecs[13] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h001,4'h1, 1'b0,1'b0,1'b0,1'b0,1'b0, 16'd1};
    vecs[14] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 12'h001,4'h1, 1'b0,1'b0,1'b0,1'b0,1'b0, 16'd0};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset", obs(), RESET_OBS);
    chk("reset_T_n", T_n, 12'hFFE);

    foreach (vecs[i]) begin
      logic [11:0] tn_exp;
      drive(vecs[i].rst, vecs[i].en, vecs[i].go, vecs[i].stp, vecs[i].mstp, vecs[i].mstrtp);
      tick();
      tn_exp = ~vecs[i].t;
      chk($sformatf("vec%0d", i), obs(), {vecs[i].t, vecs[i].phs, vecs[i].rt, vecs[i].wt, vecs[i].ct,
          vecs[i].me, vecs[i].st, vecs[i].cnt, idx_of(vecs[i].t)});
      chk($sformatf("vec%0d_T_n", i), T_n, tn_exp);
    end

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 144; k++) begin
      int tp, ph;
      tp = (k / 4) % 12;
      ph = k % 4;
      tick();
      chk($sformatf("run_k%0d", k), {T, PHS, RT, WT, CT, MCT_END},
          {12'(1) << tp, 4'(1) << ph, ph == 1, ph == 2, ph == 3, (k % 48) == 0});
    end
    chk("run_cnt3", MCT_CNT, 16'd3);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (26) tick();
    chk("pre_gojam", {T, PHS}, {12'h040, 4'h4});
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("gojam_%0d", k), {T, PHS, RT, WT, CT, MCT_END, MCT_CNT},
          {12'h800, 4'h1, 4'b0000, 16'd0});
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("gojam_rel_%0d", k), {T, PHS, MCT_END}, {12'h800, 4'(1) << k, 1'b0});
    end
    tick();
    chk("gojam_boundary", {T, PHS, MCT_END, MCT_CNT}, {12'h001, 4'h1, 1'b1, 16'd1});

    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_over_gojam", obs(), RESET_OBS);

    begin
      int n, me;
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n = 0; me = 0;
      while (!STOPPED && n < 60) begin tick(); n++; me += int'(MCT_END); end
      chk("step1_halt", {STOPPED, T, PHS, MCT_CNT}, {1'b1, 12'h000, 4'h0, 16'd1});
      chk("step1_mends", me, 1);
      repeat (5) tick();
      chk("step_hold", {STOPPED, T, MCT_END}, {1'b1, 12'h000, 1'b0});
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("step_latched_wait", STOPPED, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("step_release", {STOPPED, T, PHS, RT, WT, CT}, {1'b0, 12'h001, 4'h1, 3'b000});
      n = 0; me = 0;
      while (!STOPPED && n < 60) begin
        MSTRTP = (n == 3);
        tick(); n++; me += int'(MCT_END);
      end
      MSTRTP = 1'b0;
      chk("step2_cycles", n, 48);
      chk("step2_mends", me, 1);
      chk("step2_cnt", MCT_CNT, 16'd2);
      repeat (5) tick();
      chk("step_run_mstrtp_ignored", {STOPPED, MCT_CNT}, {1'b1, 16'd2});
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("rst_in_hold", obs(), RESET_OBS);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
